dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 17 +
 rtl/dmem_arb_pick.sv | 29 ++
 rtl/dmem_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared state encoding, port indices and default timeout for the two-port
// data-memory arbiter.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
   } arb_state_t;

   localparam int unsigned PORT0 = 0;
   localparam int unsigned PORT1 = 1;

   localparam int DEFAULT_TIMEOUT_CYCLES = 4095;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection between the two requesters; one-hot grant out.
module dmem_arb_pick
   import dmem_arb_pkg::*;
#(
   parameter int FIXED_PRIO = 0
) (
   input  logic       i_req0,
   input  logic       i_req1,
   input  logic       i_last,
   output logic [1:0] o_grant
);

   // i_last is the index of the port granted most recently
   always_comb begin
      o_grant = '0;
      if (i_req0 && i_req1) begin
         if ((FIXED_PRIO != 0) || (i_last == 1'(PORT1))) begin
            o_grant[PORT0] = 1'b1;
         end else begin
            o_grant[PORT1] = 1'b1;
         end
      end else if (i_req0) begin
         o_grant[PORT0] = 1'b1;
      end else if (i_req1) begin
         o_grant[PORT1] = 1'b1;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single stalling DataMemory: one transaction at a
// time through IDLE -> ISSUE -> WAIT -> DONE, with a WAIT timeout and sticky ERR.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int FIXED_PRIO     = 0,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic        CLK,
   input  logic        RST_X,
   input  logic        P0_REN,
   input  logic        P1_REN,
   input  logic [3:0]  P0_WEN,
   input  logic [3:0]  P1_WEN,
   input  logic [31:0] P0_ADDR,
   input  logic [31:0] P1_ADDR,
   input  logic [31:0] P0_DIN,
   input  logic [31:0] P1_DIN,
   output logic [31:0] P0_DOUT,
   output logic [31:0] P1_DOUT,
   output logic        P0_STALL,
   output logic        P1_STALL,
   output logic        M_REN,
   output logic [3:0]  M_WEN,
   output logic [31:0] M_ADDR,
   output logic [31:0] M_DIN,
   input  logic [31:0] M_DOUT,
   input  logic        M_STALL,
   output logic [1:0]  GRANT,
   output logic        ERR
);

   localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

   arb_state_t  r_state;
   arb_state_t  w_next;
   logic [1:0]  r_owner;
   logic        r_last;
   logic        r_is_read;
   logic [31:0] r_cnt;
   logic        r_err;
   logic        r_m_ren;
   logic [3:0]  r_m_wen;
   logic [31:0] r_m_addr;
   logic [31:0] r_m_din;
   logic [31:0] r_p0_dout;
   logic [31:0] r_p1_dout;

   logic        w_req0;
   logic        w_req1;
   logic [1:0]  w_pick;
   logic        w_timeout;
   logic        w_unused_addr_lsbs;

   assign w_req0    = P0_REN | (|P0_WEN);
   assign w_req1    = P1_REN | (|P1_WEN);
   assign w_timeout = (r_cnt == TO_LAST);
   assign w_unused_addr_lsbs = ^{P0_ADDR[1:0], P1_ADDR[1:0]};

   dmem_arb_pick #(
      .FIXED_PRIO(FIXED_PRIO)
   ) u_pick (
      .i_req0  (w_req0),
      .i_req1  (w_req1),
      .i_last  (r_last),
      .o_grant (w_pick)
   );

   always_ff @(posedge CLK) begin
      if (!RST_X) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      GRANT    = '0;
      P0_STALL = w_req0;
      P1_STALL = w_req1;
      case (r_state)
         ST_IDLE: begin
            if (!M_STALL && (w_pick != '0)) w_next = ST_ISSUE;
         end
         ST_ISSUE: begin
            GRANT  = r_owner;
            w_next = ST_WAIT;
         end
         ST_WAIT: begin
            GRANT = r_owner;
            if (!M_STALL || w_timeout) w_next = ST_DONE;
         end
         ST_DONE: begin
            GRANT    = r_owner;
            P0_STALL = w_req0 & ~r_owner[PORT0];
            P1_STALL = w_req1 & ~r_owner[PORT1];
            w_next   = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Command registers are loaded on the IDLE->ISSUE edge so M_REN/M_WEN are
   // high exactly for the ISSUE cycle.
   always_ff @(posedge CLK) begin
      if (!RST_X) begin
         r_owner   <= '0;
         r_last    <= 1'(PORT1);
         r_is_read <= 1'b0;
         r_cnt     <= '0;
         r_err     <= 1'b0;
         r_m_ren   <= 1'b0;
         r_m_wen   <= '0;
         r_m_addr  <= '0;
         r_m_din   <= '0;
         r_p0_dout <= '0;
         r_p1_dout <= '0;
      end else begin
         r_m_ren <= 1'b0;
         r_m_wen <= '0;
         case (r_state)
            ST_IDLE: begin
               if (w_next == ST_ISSUE) begin
                  r_owner <= w_pick;
                  r_last  <= w_pick[PORT1];
                  if (w_pick[PORT0]) begin
                     r_m_addr  <= {P0_ADDR[31:2], 2'b00};
                     r_m_din   <= P0_DIN;
                     r_m_wen   <= P0_WEN;
                     r_m_ren   <= P0_REN & (P0_WEN == '0);
                     r_is_read <= (P0_WEN == '0);
                  end else begin
                     r_m_addr  <= {P1_ADDR[31:2], 2'b00};
                     r_m_din   <= P1_DIN;
                     r_m_wen   <= P1_WEN;
                     r_m_ren   <= P1_REN & (P1_WEN == '0);
                     r_is_read <= (P1_WEN == '0);
                  end
               end
            end
            ST_ISSUE: r_cnt <= '0;
            ST_WAIT: begin
               if (!M_STALL) begin
                  if (r_is_read && r_owner[PORT0]) r_p0_dout <= M_DOUT;
                  if (r_is_read && r_owner[PORT1]) r_p1_dout <= M_DOUT;
               end else if (w_timeout) begin
                  r_err <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign M_REN   = r_m_ren;
   assign M_WEN   = r_m_wen;
   assign M_ADDR  = r_m_addr;
   assign M_DIN   = r_m_din;
   assign P0_DOUT = r_p0_dout;
   assign P1_DOUT = r_p1_dout;
   assign ERR     = r_err;

endmodule
